// File: rtl/imm_gen_stage_if.sv
// Valid/ready bundle between fetch, the immediate stage and its consumer.
// The slave modport is the stage side; master is the driving/consuming side.
interface imm_gen_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush_i;
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic [31:0]     instr_rdata_i;
    logic            valid_o;
    logic            ready_i;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] imm_o;
    logic [2:0]      imm_type_o;
    logic            illegal_o;
    logic            compressed_o;

    modport slave (
        input  flush_i, instr_valid_i, instr_rdata_i, ready_i,
        output instr_ready_o, valid_o, instr_o, imm_o,
        output imm_type_o, illegal_o, compressed_o
    );

    modport master (
        output flush_i, instr_valid_i, instr_rdata_i, ready_i,
        input  instr_ready_o, valid_o, instr_o, imm_o,
        input  imm_type_o, illegal_o, compressed_o
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate decode stage with optional 2-entry skid buffer.
// Define IMM_GEN_RVC_EN to decode 16-bit RVC immediates.
module imm_gen_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SKID = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    imm_gen_stage_if.slave   bus
);
    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z
    } imm_type_e;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        imm_type_e       ty;
        logic            illegal;
        logic            comp;
    } entry_t;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [31:0] w;
    entry_t      dec;
    assign w = bus.instr_rdata_i;

`ifdef IMM_GEN_RVC_EN
    logic [15:0] c;
    assign c = w[15:0];
`endif

    always_comb begin
        dec       = '0;
        dec.instr = w;
        if (w[1:0] == 2'b11) begin
            unique case (w[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: begin
                    dec.ty  = IMM_I;
                    dec.imm = sext(32'($signed(w[31:20])));
                end
                7'b0100011: begin
                    dec.ty  = IMM_S;
                    dec.imm = sext(32'($signed({w[31:25], w[11:7]})));
                end
                7'b1100011: begin
                    dec.ty  = IMM_B;
                    dec.imm = sext(32'($signed({w[31], w[7],
                        w[30:25], w[11:8], 1'b0})));
                end
                7'b0110111, 7'b0010111: begin
                    dec.ty  = IMM_U;
                    dec.imm = sext({w[31:12], 12'b0});
                end
                7'b1101111: begin
                    dec.ty  = IMM_J;
                    dec.imm = sext(32'($signed({w[31], w[19:12],
                        w[20], w[30:21], 1'b0})));
                end
                7'b1110011: begin
                    if (w[14]) begin
                        dec.ty  = IMM_Z;
                        dec.imm = XLEN'(w[19:15]);
                    end else begin
                        dec.ty  = IMM_I;
                        dec.imm = sext(32'($signed(w[31:20])));
                    end
                end
                7'b0110011, 7'b0001111: begin
                    dec.ty = IMM_NONE;
                end
                7'b0011011: begin
                    if (XLEN == 64) begin
                        dec.ty  = IMM_I;
                        dec.imm = sext(32'($signed(w[31:20])));
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                default: dec.illegal = 1'b1;
            endcase
        end else begin
`ifdef IMM_GEN_RVC_EN
            dec.comp = 1'b1;
            unique case ({c[1:0], c[15:13]})
                5'b01_000, 5'b01_010: begin
                    dec.ty  = IMM_I;
                    dec.imm = sext(32'($signed({c[12], c[6:2]})));
                end
                5'b01_011: begin
                    // rd 0 and 2 are reserved / C.ADDI16SP, not C.LUI
                    if (c[11:7] != 5'd0 && c[11:7] != 5'd2) begin
                        dec.ty  = IMM_U;
                        dec.imm = sext(32'($signed({c[12], c[6:2],
                            12'b0})));
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                5'b01_101: begin
                    dec.ty  = IMM_J;
                    dec.imm = sext(32'($signed({c[12], c[8], c[10:9],
                        c[6], c[7], c[2], c[11], c[5:3], 1'b0})));
                end
                5'b01_110, 5'b01_111: begin
                    dec.ty  = IMM_B;
                    dec.imm = sext(32'($signed({c[12], c[6:5], c[2],
                        c[11:10], c[4:3], 1'b0})));
                end
                5'b00_010: begin
                    dec.ty  = IMM_I;
                    dec.imm = XLEN'({c[5], c[12:10], c[6], 2'b00});
                end
                5'b00_110: begin
                    dec.ty  = IMM_S;
                    dec.imm = XLEN'({c[5], c[12:10], c[6], 2'b00});
                end
                default: dec.illegal = 1'b1;
            endcase
`else
            dec.illegal = 1'b1;
`endif
        end
    end

    state_e state_q, state_d;
    entry_t out_q, skid_q;
    logic   load_out, load_skid, promote;
    logic   in_xfer, out_xfer;

    assign bus.valid_o = (state_q != EMPTY);
    if (SKID != 0) begin : g_skid
        assign bus.instr_ready_o = (state_q != TWO);
    end else begin : g_single
        assign bus.instr_ready_o = !bus.valid_o || bus.ready_i;
    end

    assign in_xfer  = bus.instr_valid_i && bus.instr_ready_o;
    assign out_xfer = bus.valid_o && bus.ready_i;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out = 1'b1;
                end else if (in_xfer) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d = ONE;
                    promote = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush_i) begin
            state_d   = EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
            promote   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_q <= dec;
            end else if (promote) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign bus.instr_o      = out_q.instr;
    assign bus.imm_o        = out_q.imm;
    assign bus.imm_type_o   = out_q.ty;
    assign bus.illegal_o    = out_q.illegal;
    assign bus.compressed_o = out_q.comp;
endmodule
